// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial add/subtract sequencer time-sharing one full_adder cell
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;
  logic [WIDTH-1:0] sa, sb, sr, sr_nx;
  logic [CW-1:0] cnt;
  logic c, fa_sum, fa_cout, last;
  full_adder u_fa (
    .a   (sa[0]),
    .b   (sb[0]),
    .cin (c),
    .sum (fa_sum),
    .cout(fa_cout)
  );
  assign last  = (state == RUN) && (cnt == CW'(WIDTH - 1));
  assign sr_nx = WIDTH'({fa_sum, sr} >> 1);
  assign busy  = state == RUN;
  assign done  = state == DONE;
  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end
  // next-state: IDLE waits for start, RUN lasts WIDTH cycles, DONE is a single cycle
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = start ? RUN : IDLE;
      RUN:     state_nx = last ? DONE : RUN;
      default: state_nx = IDLE;
    endcase
  end
  // operand capture, serial datapath and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa       <= '0;
      sb       <= '0;
      sr       <= '0;
      c        <= 1'b0;
      cnt      <= '0;
      sum      <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else if (state == IDLE && start) begin
      sa  <= a;
      sb  <= sub ? ~b : b;
      c   <= sub;
      cnt <= '0;
    end else if (state == RUN) begin
      sr  <= sr_nx;
      sa  <= sa >> 1;
      sb  <= sb >> 1;
      c   <= fa_cout;
      cnt <= cnt + CW'(1);
      if (last) begin
        sum      <= sr_nx;
        cout     <= fa_cout;
        overflow <= c ^ fa_cout;
      end
    end
  end
endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: randomized and directed checks of serial_add_ctrl against an arithmetic model
module tb_serial_add_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic start8 = 1'b0, sub8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic busy8, done8, cout8, ov8;
  logic [7:0] sum8;
  logic start4 = 1'b0, sub4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;
  logic busy4, done4, cout4, ov4;
  logic [3:0] sum4;
  int pass_cnt = 0;
  int total_cnt = 0;

  serial_add_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .sub(sub8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .overflow(ov8)
  );
  serial_add_ctrl #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .sub(sub4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .overflow(ov4)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // arithmetic reference: two's-complement add or a + ~b + 1, modulo 2^w
  task automatic model(input int w, input int ra, input int rb, input bit rs,
                       output int s, output bit co, output bit ov);
    int mask, opb, full;
    mask = (1 << w) - 1;
    opb  = rs ? (~rb & mask) : rb;
    full = ra + opb + int'(rs);
    s    = full & mask;
    co   = ((full >> w) & 1) != 0;
    ov   = (((ra >> (w-1)) & 1) == ((opb >> (w-1)) & 1)) &&
           (((s >> (w-1)) & 1) != ((ra >> (w-1)) & 1));
  endtask

  // issue one WIDTH=8 operation; returns at the sample where done is seen (or bound expires)
  task automatic run8(input logic [7:0] ta, input logic [7:0] tbv, input logic ts,
                      output int busy_n, output int done_e, output int both);
    @(negedge clk);
    a8 = ta; b8 = tbv; sub8 = ts; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    busy_n = 0; done_e = -1; both = 0;
    for (int e = 0; e < 20; e++) begin
      if (busy8) busy_n++;
      if (busy8 && done8) both++;
      if (done8) begin
        done_e = e;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    #2 rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({busy8, done8, sum8, cout8, ov8} !== 12'h000) $display("FAIL reset8: got %h want 000", {busy8, done8, sum8, cout8, ov8});
    else pass_cnt++;
    total_cnt++;
    if ({busy4, done4, sum4, cout4, ov4} !== 8'h00) $display("FAIL reset4: got %h want 00", {busy4, done4, sum4, cout4, ov4});
    else pass_cnt++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    total_cnt++;
    if ({busy8, done8} !== 2'b00) $display("FAIL idle_after_reset: busy/done %b want 00", {busy8, done8});
    else pass_cnt++;
  endtask

  task automatic test_add;
    int bn, de, bo;
    run8(8'h5A, 8'h3C, 1'b0, bn, de, bo);
    total_cnt++;
    if ({sum8, cout8, ov8} !== {8'h96, 1'b0, 1'b1}) $display("FAIL add_5a_3c: got sum=%h cout=%b ov=%b want 96/0/1", sum8, cout8, ov8);
    else pass_cnt++;
    total_cnt++;
    if (de !== 8) $display("FAIL done_latency: got edge %0d want 8", de);
    else pass_cnt++;
    total_cnt++;
    if (bn !== 8) $display("FAIL busy_cycles: got %0d want 8", bn);
    else pass_cnt++;
    total_cnt++;
    if (bo !== 0) $display("FAIL busy_done_overlap: got %0d want 0", bo);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if ({busy8, done8} !== 2'b00) $display("FAIL done_pulse_width: busy/done %b want 00", {busy8, done8});
    else pass_cnt++;
    run8(8'hFF, 8'h01, 1'b0, bn, de, bo);
    total_cnt++;
    if ({sum8, cout8, ov8} !== {8'h00, 1'b1, 1'b0}) $display("FAIL add_ff_01: got sum=%h cout=%b ov=%b want 00/1/0", sum8, cout8, ov8);
    else pass_cnt++;
  endtask

  task automatic test_sub;
    int bn, de, bo;
    run8(8'h10, 8'h20, 1'b1, bn, de, bo);
    total_cnt++;
    if ({sum8, cout8, ov8} !== {8'hF0, 1'b0, 1'b0}) $display("FAIL sub_10_20: got sum=%h cout=%b ov=%b want f0/0/0", sum8, cout8, ov8);
    else pass_cnt++;
    run8(8'h80, 8'h01, 1'b1, bn, de, bo);
    total_cnt++;
    if ({sum8, cout8, ov8} !== {8'h7F, 1'b1, 1'b1}) $display("FAIL sub_80_01: got sum=%h cout=%b ov=%b want 7f/1/1", sum8, cout8, ov8);
    else pass_cnt++;
  endtask

  task automatic test_random8;
    int bn, de, bo, s;
    bit co, ov;
    logic [7:0] ra, rb;
    logic rs;
    for (int i = 0; i < 24; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rs = 1'($urandom);
      run8(ra, rb, rs, bn, de, bo);
      model(8, int'(ra), int'(rb), rs, s, co, ov);
      total_cnt++;
      if ({de, sum8, cout8, ov8} !== {8, 8'(s), co, ov})
        $display("FAIL rand8 a=%h b=%h sub=%b: got edge=%0d sum=%h cout=%b ov=%b want 8/%h/%b/%b", ra, rb, rs, de, sum8, cout8, ov8, 8'(s), co, ov);
      else pass_cnt++;
    end
  endtask

  task automatic test_ignore_inputs;
    int done_n = 0;
    int bad = 0;
    @(negedge clk);
    a8 = 8'h5A; b8 = 8'h3C; sub8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    start8 = 1'b1; a8 = 8'h01; b8 = 8'h01;
    @(negedge clk);
    start8 = 1'b0; a8 = 8'hFF; b8 = 8'hFF; sub8 = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (done8) begin
        done_n++;
        if ({sum8, cout8, ov8} !== {8'h96, 1'b0, 1'b1}) bad++;
      end
      @(negedge clk);
    end
    total_cnt++;
    if (done_n !== 1) $display("FAIL ignore_start_done_count: got %0d want 1", done_n);
    else pass_cnt++;
    total_cnt++;
    if (bad !== 0) $display("FAIL ignore_operand_change: got %0d wrong results want 0", bad);
    else pass_cnt++;
    total_cnt++;
    if ({sum8, cout8, ov8} !== {8'h96, 1'b0, 1'b1}) $display("FAIL result_hold: got sum=%h cout=%b ov=%b want 96/0/1", sum8, cout8, ov8);
    else pass_cnt++;
    sub8 = 1'b0;
  endtask

  task automatic test_async_reset;
    int bn, de, bo;
    int done_n = 0;
    @(negedge clk);
    a8 = 8'h5A; b8 = 8'h3C; sub8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({busy8, done8, sum8, cout8, ov8} !== 12'h000) $display("FAIL midrun_reset: got %h want 000", {busy8, done8, sum8, cout8, ov8});
    else pass_cnt++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (done8) done_n++;
      @(negedge clk);
    end
    total_cnt++;
    if (done_n !== 0 || sum8 !== 8'h00) $display("FAIL no_done_after_abort: got %0d pulses sum=%h want 0/00", done_n, sum8);
    else pass_cnt++;
    run8(8'h01, 8'h02, 1'b0, bn, de, bo);
    total_cnt++;
    if ({de, sum8, cout8, ov8} !== {8, 8'h03, 1'b0, 1'b0}) $display("FAIL post_reset_run: got edge=%0d sum=%h want 8/03", de, sum8);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back_sweep4;
    int s;
    bit co, ov;
    @(negedge clk);
    for (int rs = 0; rs < 2; rs++)
      for (int ra = 0; ra < 16; ra++)
        for (int rb = 0; rb < 16; rb++) begin
          a4 = 4'(ra); b4 = 4'(rb); sub4 = 1'(rs); start4 = 1'b1;
          @(negedge clk);
          start4 = 1'b0;
          a4 = ~a4; b4 = ~b4;
          repeat (4) @(negedge clk);
          model(4, ra, rb, 1'(rs), s, co, ov);
          total_cnt++;
          if ({done4, busy4, sum4, cout4, ov4} !== {1'b1, 1'b0, 4'(s), co, ov})
            $display("FAIL sweep4 a=%h b=%h sub=%0d: got done=%b busy=%b sum=%h cout=%b ov=%b want 1/0/%h/%b/%b",
                     ra, rb, rs, done4, busy4, sum4, cout4, ov4, 4'(s), co, ov);
          else pass_cnt++;
          @(negedge clk);
        end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_random8();
    test_ignore_inputs();
    test_async_reset();
    test_back_to_back_sweep4();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
